inout_sram_arbiter: RTL and testbench

Burst-level round-robin arbiter sharing the 384 kB InOut SRAM (six 32768×16-bit banks, 1-cycle registered read) between NUM_REQ requesters: input loader, PE read path, PE writeback. It grants the SRAM to one requester for a whole burst, drives the SRAM control/address/data, enforces the SRAM's read-data timing, and routes read data back with a per-requester valid strobe. It also bounds burst length and rejects out-of-range addresses.

---
 rtl/inout_sram_arbiter_if.sv | 28 ++
 rtl/inout_sram_arbiter.sv | 134 +++++++++++++
 tb/tb_inout_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inout_sram_arbiter_if.sv
// Requester-side bus of the InOut SRAM arbiter: per-requester beat request
// fields plus grant, read-return and status signals.
interface inout_sram_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0]             we_i;
    logic [NUM_REQ-1:0]             last_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]             gnt_o;
    logic [NUM_REQ-1:0]             rvalid_o;
    logic [DATA_W-1:0]              rdata_o;
    logic                           err_o;
    logic                           busy_o;

    modport master (
        output req_i, we_i, last_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, last_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/inout_sram_arbiter.sv
// Burst-level round-robin arbiter for the shared InOut SRAM with a 1-deep
// registered read-return pipe, burst-length cap and address range check.
module inout_sram_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned ADDR_LIMIT = 196608
) (
    input  logic                clk,
    input  logic                rst_n,
    inout_sram_arbiter_if.slave bus,
    output logic                mem_cs,
    output logic                mem_oe,
    output logic                mem_web,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);
    localparam int unsigned OWN_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic [OWN_W-1:0]   rd_owner_q, rd_owner_d;
    logic               rd_oob_q, rd_oob_d;

    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic               cur_we, cur_last, acc, oob, found;
    logic [OWN_W-1:0]   pick, cand;
    logic               unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata[31:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    // Rotating priority: first requester at or above ptr_q, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = OWN_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        cur_addr  = bus.addr_i[owner_q];
        cur_wdata = bus.wdata_i[owner_q];
        cur_we    = bus.we_i[owner_q];
        cur_last  = bus.last_i[owner_q];
        oob       = 32'(cur_addr) >= ADDR_LIMIT;
        acc       = (state_q == BURST) && bus.req_i[owner_q];

        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = owner_q;
        rd_oob_d   = oob;
        bus.gnt_o  = '0;
        bus.err_o  = 1'b0;
        mem_cs     = 1'b0;
        mem_web    = 1'b1;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (acc) begin
                    bus.gnt_o[owner_q] = 1'b1;
                    bus.err_o          = oob;
                    if (!oob) begin
                        mem_cs    = 1'b1;
                        mem_web   = ~cur_we;
                        mem_addr  = 32'(cur_addr);
                        mem_wdata = 32'(cur_wdata);
                    end
                    rd_pend_d = ~cur_we;
                    cnt_d     = cnt_q + 1'b1;
                    if (cur_last || cnt_d == CNT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                        ptr_d   = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rvalid_o = '0;
        if (rd_pend_q) bus.rvalid_o[rd_owner_q] = 1'b1;
        mem_oe       = rd_pend_q & ~rd_oob_q;
        bus.rdata_o  = mem_oe ? mem_rdata[DATA_W-1:0] : '0;
        bus.busy_o   = (state_q == BURST);
    end
endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Randomized + directed bench for inout_sram_arbiter against a beat-level
// reference model with its own copy of memory contents.
module tb_inout_sram_arbiter;
    localparam int NR    = 3;
    localparam int LIMIT = 196608;
    localparam int MAXB  = 64;

    logic        clk;
    logic        rst_n;
    logic        mem_cs, mem_oe, mem_web;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    inout_sram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(18), .DATA_W(16)) bus ();

    inout_sram_arbiter #(
        .NUM_REQ(NR), .ADDR_W(18), .DATA_W(16), .MAX_BURST(MAXB), .ADDR_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: registered read, junk on the bus when not reading
    logic [15:0] sram [0:LIMIT-1];
    always @(posedge clk) begin
        if (mem_cs && !mem_web) sram[mem_addr[17:0]] <= mem_wdata[15:0];
        if (mem_cs && mem_web) mem_rdata <= {16'($urandom), sram[mem_addr[17:0]]};
        else                   mem_rdata <= $urandom;
    end

    typedef struct {
        logic        we;
        logic        last;
        logic [17:0] addr;
        logic [15:0] data;
    } beat_t;

    beat_t       bq [NR][$];
    logic [15:0] ref_mem [0:LIMIT-1];

    int n_checks = 0;
    int n_pass   = 0;

    bit          m_busy;
    int          m_owner, m_ptr, m_cnt;
    bit          m_rv, m_rv_oob;
    int          m_rv_owner;
    logic [15:0] m_rv_data;
    int          acc_cnt [NR];
    bit          hold_en;

    int          run1, max_run1;
    bit          burst_seen;
    int          order_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_burst(input int r, input bit we, input int n,
                              input logic [17:0] base, input logic [15:0] dbase);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.we   = we;
            b.last = (i == n - 1);
            b.addr = base + 18'(i);
            b.data = dbase + 16'(i);
            bq[r].push_back(b);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_rv = 0; m_rv_oob = 0; m_rv_owner = 0; m_rv_data = '0;
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (bq[r].size() > 0 && !(hold_en && $urandom_range(0, 7) == 0)) begin
                bus.req_i[r]   = 1'b1;
                bus.we_i[r]    = bq[r][0].we;
                bus.last_i[r]  = bq[r][0].last;
                bus.addr_i[r]  = bq[r][0].addr;
                bus.wdata_i[r] = bq[r][0].data;
            end else begin
                bus.req_i[r]   = 1'b0;
                bus.we_i[r]    = 1'($urandom);
                bus.last_i[r]  = 1'($urandom);
                bus.addr_i[r]  = 18'($urandom);
                bus.wdata_i[r] = 16'($urandom);
            end
        end
    endtask

    task automatic step();
        logic [NR-1:0] e_gnt, e_rv;
        logic [15:0]   e_rdata;
        logic [31:0]   e_addr, e_wd;
        bit            e_err, e_cs, e_web, e_oe, e_busy, oob, n_rv, n_oob;
        int            n_owner, a;
        logic [15:0]   n_data;

        @(posedge clk); #1;
        drive();
        @(negedge clk);

        e_gnt = '0; e_err = 0; e_cs = 0; e_web = 1; e_addr = '0; e_wd = '0;
        e_rv    = '0;
        if (m_rv) e_rv[m_rv_owner] = 1'b1;
        e_rdata = (m_rv && !m_rv_oob) ? m_rv_data : 16'h0;
        e_oe    = m_rv && !m_rv_oob;
        e_busy  = m_busy;
        n_rv = 0; n_oob = 0; n_owner = 0; n_data = '0;

        if (m_busy) begin
            if (bus.req_i[m_owner]) begin
                a   = int'(bus.addr_i[m_owner]);
                oob = (a >= LIMIT);
                e_gnt[m_owner] = 1'b1;
                e_err = oob;
                if (!oob) begin
                    e_cs   = 1;
                    e_web  = !bus.we_i[m_owner];
                    e_addr = 32'(a);
                    e_wd   = 32'(bus.wdata_i[m_owner]);
                end
                if (bus.we_i[m_owner]) begin
                    if (!oob) ref_mem[a] = bus.wdata_i[m_owner];
                end else begin
                    n_rv = 1; n_owner = m_owner; n_oob = oob;
                    n_data = oob ? 16'h0 : ref_mem[a];
                end
                acc_cnt[m_owner]++;
                void'(bq[m_owner].pop_front());
                m_cnt++;
                if (bus.last_i[m_owner] || m_cnt == MAXB) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % NR;
                end
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (!m_busy && bus.req_i[(m_ptr + k) % NR]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % NR;
                    m_cnt   = 0;
                end
            end
        end
        m_rv = n_rv; m_rv_owner = n_owner; m_rv_oob = n_oob; m_rv_data = n_data;

        check("gnt",    32'(bus.gnt_o),    32'(e_gnt));
        check("rvalid", 32'(bus.rvalid_o), 32'(e_rv));
        check("rdata",  32'(bus.rdata_o),  32'(e_rdata));
        check("err",    32'(bus.err_o),    32'(e_err));
        check("busy",   32'(bus.busy_o),   32'(e_busy));
        check("mem_cs", 32'(mem_cs),       32'(e_cs));
        check("mem_oe", 32'(mem_oe),       32'(e_oe));
        check("mem_web",32'(mem_web),      32'(e_web));
        if (e_cs) begin
            check("mem_addr",  mem_addr,  e_addr);
            check("mem_wdata", mem_wdata, e_wd);
        end

        // observations for burst-level checks
        if (bus.gnt_o[1]) run1++;
        if (!bus.busy_o) run1 = 0;
        if (run1 > max_run1) max_run1 = run1;
        if (bus.gnt_o != '0 && !burst_seen) begin
            for (int r = 0; r < NR; r++) if (bus.gnt_o[r]) order_q.push_back(r);
            burst_seen = 1;
        end
        if (!bus.busy_o) burst_seen = 0;
    endtask

    function automatic bit work_left();
        return bq[0].size() > 0 || bq[1].size() > 0 || bq[2].size() > 0 || m_busy || m_rv;
    endfunction

    task automatic drain(input int maxc);
        int c = 0;
        while (work_left() && c < maxc) begin
            step();
            c++;
        end
        check("drain_timeout", 32'(work_left()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},    32'(bus.gnt_o),    32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
        check({tag, "_rdata"},  32'(bus.rdata_o),  32'd0);
        check({tag, "_err"},    32'(bus.err_o),    32'd0);
        check({tag, "_busy"},   32'(bus.busy_o),   32'd0);
        check({tag, "_cs"},     32'(mem_cs),       32'd0);
        check({tag, "_oe"},     32'(mem_oe),       32'd0);
        check({tag, "_web"},    32'(mem_web),      32'd1);
        check({tag, "_addr"},   mem_addr,          32'd0);
    endtask

    initial begin
        int start0, c;
        for (int i = 0; i < LIMIT; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        for (int r = 0; r < NR; r++) acc_cnt[r] = 0;
        model_reset();
        hold_en = 0; run1 = 0; max_run1 = 0; burst_seen = 0;
        rst_n = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // round-robin from reset: owners 0,1,2,0,1,2
        for (int n = 0; n < 2; n++)
            for (int r = 0; r < NR; r++)
                push_burst(r, 1, 2, 18'(16'h200 + 16'(r * 16 + n * 4)), 16'(16'h1100 * (r + 1)));
        order_q.delete();
        drain(100);
        check("rr_count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check("rr_order", 32'(order_q[i]), 32'(i % NR));

        // single requester write then read-back
        push_burst(0, 1, 4, 18'h00010, 16'hA000);
        drain(50);
        push_burst(0, 0, 4, 18'h00010, 16'h0);
        drain(50);

        // forced release at MAX_BURST
        push_burst(1, 1, 100, 18'h00400, 16'h5000);
        step();
        push_burst(2, 1, 3, 18'h00600, 16'h6000);
        max_run1 = 0; run1 = 0;
        drain(300);
        check("forced_run", 32'(max_run1), 32'(MAXB));

        // out-of-range read and write
        push_burst(0, 0, 1, 18'h30000, 16'h0);
        push_burst(0, 1, 1, 18'h3FFFF, 16'h1234);
        drain(50);

        // bank crossing
        bq[2].push_back('{we: 1'b1, last: 1'b0, addr: 18'h07FFF, data: 16'hBEEF});
        bq[2].push_back('{we: 1'b1, last: 1'b1, addr: 18'h08000, data: 16'hCAFE});
        bq[2].push_back('{we: 1'b0, last: 1'b0, addr: 18'h07FFF, data: 16'h0});
        bq[2].push_back('{we: 1'b0, last: 1'b1, addr: 18'h08000, data: 16'h0});
        drain(50);

        // randomized traffic with request gaps
        hold_en = 1;
        for (int t = 0; t < 600; t++) begin
            for (int r = 0; r < NR; r++) begin
                if (bq[r].size() == 0 && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       push_burst(r, 1'($urandom), int'($urandom_range(1, 8)), 18'(LIMIT - 4), 16'($urandom));
                        1:       push_burst(r, 1'($urandom), int'($urandom_range(1, 8)), 18'(32764 + $urandom_range(0, 4)), 16'($urandom));
                        default: push_burst(r, 1'($urandom), int'($urandom_range(1, 8)), 18'($urandom_range(0, 255)), 16'($urandom));
                    endcase
                end
            end
            step();
        end
        for (int r = 0; r < NR; r++) push_burst(r, 1, 1, 18'h00300, 16'h7777);
        drain(2000);
        hold_en = 0;

        // reset during the third beat of a 5-beat read burst
        start0 = acc_cnt[0];
        push_burst(0, 0, 5, 18'h00010, 16'h0);
        c = 0;
        while (acc_cnt[0] < start0 + 2 && c < 20) begin
            step();
            c++;
        end
        check("rst_setup", 32'(acc_cnt[0] - start0), 32'd2);
        @(posedge clk); #1;
        drive();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        for (int r = 0; r < NR; r++) bq[r].delete();
        model_reset();
        drive();
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        step();
        step();
        push_burst(0, 0, 2, 18'h00011, 16'h0);
        drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
